// File: rtl/axi_pkg.sv
// Shared AXI definitions used by the memory slaves.
// Provides burst/response encodings and a transfer-size helper.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Number of bytes moved by one beat of the given AXI size code.
  function automatic logic [7:0] axi_size_bytes(input logic [2:0] size);
    return 8'd1 << size;
  endfunction

endpackage

// File: rtl/other_mem_slave_pkg.sv
// Local definitions for the other_mem_slave block: FSM state encoding and
// wait-state counter width.
package other_mem_slave_pkg;

  localparam int unsigned WAIT_CNT_W = 4;

  // One-hot access FSM.
  typedef enum logic [2:0] {
    StIdle = 3'b001,
    StWait = 3'b010,
    StDone = 3'b100
  } state_e;

endpackage

// File: rtl/other_mem_slave_if.sv
// Simple request/ready memory bus between a requester and other_mem_slave.
// Signals:
//   other_sel_in / other_write_in / other_addr_in / other_size_in /
//   other_prot_in / other_wdata_in / other_strb_in : request (master -> slave)
//   other_ready_out / other_error_out / other_rdata_out : response (slave -> master)
interface other_mem_slave_if #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32
);
  localparam int unsigned AXI_WSTRB_WIDTH = AXI_DATA_WIDTH / 8;

  logic                       other_sel_in;
  logic                       other_write_in;
  logic [AXI_ADDR_WIDTH-1:0]  other_addr_in;
  logic [2:0]                 other_size_in;
  logic [2:0]                 other_prot_in;
  logic [AXI_DATA_WIDTH-1:0]  other_wdata_in;
  logic [AXI_WSTRB_WIDTH-1:0] other_strb_in;
  logic                       other_ready_out;
  logic                       other_error_out;
  logic [AXI_DATA_WIDTH-1:0]  other_rdata_out;

  modport master (
    output other_sel_in, other_write_in, other_addr_in, other_size_in,
           other_prot_in, other_wdata_in, other_strb_in,
    input  other_ready_out, other_error_out, other_rdata_out
  );

  modport slave (
    input  other_sel_in, other_write_in, other_addr_in, other_size_in,
           other_prot_in, other_wdata_in, other_strb_in,
    output other_ready_out, other_error_out, other_rdata_out
  );

endinterface

// File: rtl/other_mem_ram.sv
// Single-port RAM with per-byte write enables and a registered read port.
// Ports:
//   clk, rst_n : clock and async active-low reset (read register only)
//   en, we     : access enable, 1=write / 0=read
//   strb       : byte enables for writes
//   addr       : word index
//   wdata      : write data
//   rdata      : read data, updated only by read accesses
module other_mem_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 256,
  localparam int unsigned STRB_W = DATA_W / 8,
  localparam int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              we,
  input  logic [STRB_W-1:0] strb,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (strb[b]) begin
          mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/other_mem_slave.sv
// Memory slave with configurable wait states and access checking.
// Ports:
//   axi_clk_in  : clock, rising edge
//   axi_rstn_in : async active-low reset
//   bus         : request/response bus (slave modport)
// A request is accepted whenever sel and ready are both high. The memory
// access happens on the edge that enters DONE; ready is low while waiting.
module other_mem_slave
  import axi_pkg::*;
  import other_mem_slave_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH      = 256,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int unsigned WAIT_CYCLES    = 0
) (
  input logic              axi_clk_in,
  input logic              axi_rstn_in,
  other_mem_slave_if.slave bus
);

  localparam int unsigned AXI_WSTRB_WIDTH = AXI_DATA_WIDTH / 8;
  localparam int unsigned BYTE_SHIFT      = $clog2(AXI_WSTRB_WIDTH);
  localparam int unsigned IDX_W           = $clog2(MEM_DEPTH);
  localparam logic [AXI_ADDR_WIDTH:0] MEM_BYTES =
      (AXI_ADDR_WIDTH + 1)'(MEM_DEPTH * AXI_WSTRB_WIDTH);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
      (WAIT_CYCLES == 0) ? '0 : WAIT_CNT_W'(WAIT_CYCLES - 1);

  state_e                      state_q, state_d;
  logic [WAIT_CNT_W-1:0]       cnt_q, cnt_d;

  // Captured request, used while waiting.
  logic                        write_q;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [2:0]                  size_q;
  logic [2:0]                  prot_q;
  logic [AXI_DATA_WIDTH-1:0]   wdata_q;
  logic [AXI_WSTRB_WIDTH-1:0]  strb_q;

  logic                        err_q;
  logic                        rd_zero_q;

  logic                        ready;
  logic                        accept;
  logic                        done_entry;

  // Request fields seen by the access logic at the DONE-entry edge.
  logic                        cur_write;
  logic [AXI_ADDR_WIDTH-1:0]   cur_addr;
  logic [2:0]                  cur_size;
  logic [2:0]                  cur_prot;
  logic [AXI_DATA_WIDTH-1:0]   cur_wdata;
  logic [AXI_WSTRB_WIDTH-1:0]  cur_strb;

  logic [AXI_ADDR_WIDTH-1:0]   offset;
  logic [IDX_W-1:0]            word_idx;
  logic                        in_range;
  logic                        size_bad;
  logic                        misaligned;
  logic                        prot_bad;
  logic                        cur_err;

  logic [AXI_DATA_WIDTH-1:0]   ram_rdata;
  logic                        unused_prot;

  assign ready  = (state_q != StWait);
  assign accept = bus.other_sel_in && ready;

  // Outside WAIT the DONE-entry edge is the accept edge, so the live inputs
  // are the request; inside WAIT only the captured copy is valid.
  always_comb begin
    if (state_q == StWait) begin
      cur_write = write_q;
      cur_addr  = addr_q;
      cur_size  = size_q;
      cur_prot  = prot_q;
      cur_wdata = wdata_q;
      cur_strb  = strb_q;
    end else begin
      cur_write = bus.other_write_in;
      cur_addr  = bus.other_addr_in;
      cur_size  = bus.other_size_in;
      cur_prot  = bus.other_prot_in;
      cur_wdata = bus.other_wdata_in;
      cur_strb  = bus.other_strb_in;
    end
  end

  assign unused_prot = ^cur_prot[2:1];

  always_comb begin
    offset     = cur_addr - BASE_ADDR;
    word_idx   = IDX_W'(offset >> BYTE_SHIFT);
    in_range   = (cur_addr >= BASE_ADDR) && ({1'b0, offset} < MEM_BYTES);
    size_bad   = cur_size > 3'(BYTE_SHIFT);
    misaligned = (8'(cur_addr) & (axi_size_bytes(cur_size) - 8'd1)) != 8'd0;
    // Upper half of memory is writable only with prot[0] set.
    prot_bad   = cur_write && !cur_prot[0] && word_idx[IDX_W-1];
    cur_err    = !in_range || size_bad || misaligned || prot_bad;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_d = StDone;
          end else begin
            state_d = StWait;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign done_entry = (state_d == StDone) && ((state_q == StWait) || accept);

  always_ff @(posedge axi_clk_in or negedge axi_rstn_in) begin
    if (!axi_rstn_in) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge axi_clk_in or negedge axi_rstn_in) begin
    if (!axi_rstn_in) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      prot_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else if (accept) begin
      write_q <= bus.other_write_in;
      addr_q  <= bus.other_addr_in;
      size_q  <= bus.other_size_in;
      prot_q  <= bus.other_prot_in;
      wdata_q <= bus.other_wdata_in;
      strb_q  <= bus.other_strb_in;
    end
  end

  // rd_zero_q masks the RAM read register after an errored read and stays
  // set until the next good read, so writes never disturb rdata.
  always_ff @(posedge axi_clk_in or negedge axi_rstn_in) begin
    if (!axi_rstn_in) begin
      err_q     <= 1'b0;
      rd_zero_q <= 1'b0;
    end else if (done_entry) begin
      err_q <= cur_err;
      if (!cur_write) begin
        rd_zero_q <= cur_err;
      end
    end
  end

  other_mem_ram #(
    .DATA_W (AXI_DATA_WIDTH),
    .DEPTH  (MEM_DEPTH)
  ) u_ram (
    .clk   (axi_clk_in),
    .rst_n (axi_rstn_in),
    .en    (done_entry && !cur_err),
    .we    (cur_write),
    .strb  (cur_strb),
    .addr  (word_idx),
    .wdata (cur_wdata),
    .rdata (ram_rdata)
  );

  assign bus.other_ready_out = ready;
  assign bus.other_error_out = (state_q == StDone) && err_q;
  assign bus.other_rdata_out = rd_zero_q ? '0 : ram_rdata;

endmodule

// File: tb/tb_other_mem_slave.sv
// Bench for other_mem_slave: three instances with WAIT_CYCLES of 0, 3 and 5.
module tb_other_mem_slave;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        sel   [3];
  logic        write [3];
  logic [31:0] addr  [3];
  logic [2:0]  size  [3];
  logic [2:0]  prot  [3];
  logic [31:0] wdata [3];
  logic [3:0]  strb  [3];
  logic [2:0]  rdy;
  logic [2:0]  errs;
  logic [31:0] rd    [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    other_mem_slave_if #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32)) bus ();

    other_mem_slave #(
      .AXI_ADDR_WIDTH (32),
      .AXI_DATA_WIDTH (32),
      .MEM_DEPTH      (256),
      .BASE_ADDR      (32'h0),
      .WAIT_CYCLES    (g == 0 ? 0 : (g == 1 ? 3 : 5))
    ) u_dut (
      .axi_clk_in  (clk),
      .axi_rstn_in (rst_n),
      .bus         (bus)
    );

    assign bus.other_sel_in   = sel[g];
    assign bus.other_write_in = write[g];
    assign bus.other_addr_in  = addr[g];
    assign bus.other_size_in  = size[g];
    assign bus.other_prot_in  = prot[g];
    assign bus.other_wdata_in = wdata[g];
    assign bus.other_strb_in  = strb[g];
    assign rdy[g]  = bus.other_ready_out;
    assign errs[g] = bus.other_error_out;
    assign rd[g]   = bus.other_rdata_out;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  // One complete access on instance d; returns DONE-cycle error/rdata and the
  // number of sampled cycles with ready low. Inputs are scrambled while
  // waiting so that only the captured request can be used.
  task automatic access(input int d, input logic wr, input logic [31:0] a,
                        input logic [2:0] sz, input logic [2:0] pr,
                        input logic [31:0] wd, input logic [3:0] sb,
                        output logic e, output logic [31:0] r, output int lows);
    @(negedge clk);
    sel[d] = 1'b1; write[d] = wr; addr[d] = a; size[d] = sz;
    prot[d] = pr; wdata[d] = wd; strb[d] = sb;
    @(posedge clk);
    @(negedge clk);
    sel[d] = 1'b0; write[d] = !wr; addr[d] = 32'hFFFF_FFF0;
    wdata[d] = 32'h0; strb[d] = 4'hF; size[d] = 3'd2;
    lows = 0;
    while (!rdy[d] && lows < 20) begin
      lows++;
      @(negedge clk);
    end
    e = errs[d];
    r = rd[d];
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [2:0]  sz;
    logic [2:0]  pr;
    logic [31:0] wd;
    logic [3:0]  sb;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [21];

  initial begin
    logic        e;
    logic [31:0] r;
    int          lows;

    //            wr    addr        sz    pr    wdata         strb  err   rdata
    vecs[0]  = '{1'b1, 32'h010, 3'd2, 3'd1, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h010, 3'd2, 3'd1, 32'h0,        4'hF, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 32'h010, 3'd2, 3'd1, 32'h000000AA, 4'h1, 1'b0, 32'hDEADBEEF};
    vecs[3]  = '{1'b0, 32'h010, 3'd2, 3'd1, 32'h0,        4'hF, 1'b0, 32'hDEADBEAA};
    vecs[4]  = '{1'b0, 32'h400, 3'd2, 3'd1, 32'h0,        4'hF, 1'b1, 32'h0};
    vecs[5]  = '{1'b1, 32'h011, 3'd2, 3'd1, 32'h12345678, 4'hF, 1'b1, 32'h0};
    vecs[6]  = '{1'b0, 32'h010, 3'd2, 3'd1, 32'h0,        4'hF, 1'b0, 32'hDEADBEAA};
    vecs[7]  = '{1'b1, 32'h200, 3'd2, 3'd1, 32'hCAFEF00D, 4'hF, 1'b0, 32'hDEADBEAA};
    vecs[8]  = '{1'b1, 32'h200, 3'd2, 3'd0, 32'h11111111, 4'hF, 1'b1, 32'hDEADBEAA};
    vecs[9]  = '{1'b0, 32'h200, 3'd2, 3'd0, 32'h0,        4'hF, 1'b0, 32'hCAFEF00D};
    vecs[10] = '{1'b1, 32'h1FC, 3'd2, 3'd0, 32'h5A5A5A5A, 4'hF, 1'b0, 32'hCAFEF00D};
    vecs[11] = '{1'b0, 32'h1FC, 3'd2, 3'd0, 32'h0,        4'hF, 1'b0, 32'h5A5A5A5A};
    vecs[12] = '{1'b0, 32'h012, 3'd1, 3'd1, 32'h0,        4'hF, 1'b0, 32'hDEADBEAA};
    vecs[13] = '{1'b0, 32'h010, 3'd3, 3'd1, 32'h0,        4'hF, 1'b1, 32'h0};
    vecs[14] = '{1'b1, 32'h3FC, 3'd2, 3'd1, 32'hA5A5A5A5, 4'hF, 1'b0, 32'h0};
    vecs[15] = '{1'b1, 32'h3FC, 3'd2, 3'd1, 32'h01020304, 4'hC, 1'b0, 32'h0};
    vecs[16] = '{1'b0, 32'h3FF, 3'd0, 3'd1, 32'h0,        4'hF, 1'b0, 32'h0102A5A5};
    vecs[17] = '{1'b0, 32'h400, 3'd0, 3'd1, 32'h0,        4'hF, 1'b1, 32'h0};
    vecs[18] = '{1'b0, 32'h012, 3'd2, 3'd1, 32'h0,        4'hF, 1'b1, 32'h0};
    vecs[19] = '{1'b1, 32'h000, 3'd2, 3'd1, 32'h11223344, 4'hF, 1'b0, 32'h0};
    vecs[20] = '{1'b1, 32'h004, 3'd2, 3'd1, 32'h55667788, 4'hF, 1'b0, 32'h0};

    for (int d = 0; d < 3; d++) begin
      sel[d] = 1'b0; write[d] = 1'b0; addr[d] = '0; size[d] = 3'd2;
      prot[d] = 3'd1; wdata[d] = '0; strb[d] = 4'hF;
    end

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset ready u%0d", d), 32'(rdy[d]), 32'd1);
      check($sformatf("reset error u%0d", d), 32'(errs[d]), 32'd0);
      check($sformatf("reset rdata u%0d", d), rd[d], 32'h0);
    end
    rst_n = 1'b1;

    // Zero-wait table
    foreach (vecs[i]) begin
      access(0, vecs[i].wr, vecs[i].a, vecs[i].sz, vecs[i].pr, vecs[i].wd, vecs[i].sb,
             e, r, lows);
      check($sformatf("v%0d ready_low_cycles", i), 32'(lows), 32'd0);
      check($sformatf("v%0d error", i), 32'(e), 32'(vecs[i].exp_err));
      check($sformatf("v%0d rdata", i), r, vecs[i].exp_rd);
    end

    // Back-to-back reads with sel held: second accept happens in DONE
    @(negedge clk);
    sel[0] = 1'b1; write[0] = 1'b0; addr[0] = 32'h0; size[0] = 3'd2;
    @(posedge clk);
    @(negedge clk);
    check("b2b first ready", 32'(rdy[0]), 32'd1);
    check("b2b first rdata", rd[0], 32'h11223344);
    addr[0] = 32'h4;
    @(posedge clk);
    @(negedge clk);
    sel[0] = 1'b0;
    check("b2b second ready", 32'(rdy[0]), 32'd1);
    check("b2b second error", 32'(errs[0]), 32'd0);
    check("b2b second rdata", rd[0], 32'h55667788);

    // Three wait states
    access(1, 1'b1, 32'h20, 3'd2, 3'd1, 32'h0BADF00D, 4'hF, e, r, lows);
    check("w3 write ready_low_cycles", 32'(lows), 32'd3);
    check("w3 write error", 32'(e), 32'd0);
    access(1, 1'b0, 32'h20, 3'd2, 3'd1, 32'h0, 4'hF, e, r, lows);
    check("w3 read ready_low_cycles", 32'(lows), 32'd3);
    check("w3 read error", 32'(e), 32'd0);
    check("w3 read rdata", r, 32'h0BADF00D);
    @(negedge clk);
    check("w3 idle ready", 32'(rdy[1]), 32'd1);
    check("w3 idle rdata held", rd[1], 32'h0BADF00D);
    access(1, 1'b0, 32'h400, 3'd2, 3'd1, 32'h0, 4'hF, e, r, lows);
    check("w3 err read ready_low_cycles", 32'(lows), 32'd3);
    check("w3 err read error", 32'(e), 32'd1);
    check("w3 err read rdata", r, 32'h0);

    // Five wait states, reset asserted mid-write
    access(2, 1'b1, 32'h30, 3'd2, 3'd1, 32'h600DCAFE, 4'hF, e, r, lows);
    check("w5 write ready_low_cycles", 32'(lows), 32'd5);
    access(2, 1'b0, 32'h30, 3'd2, 3'd1, 32'h0, 4'hF, e, r, lows);
    check("w5 read rdata", r, 32'h600DCAFE);
    @(negedge clk);
    sel[2] = 1'b1; write[2] = 1'b1; addr[2] = 32'h30; size[2] = 3'd2;
    prot[2] = 3'd1; wdata[2] = 32'hBAD0BAD0; strb[2] = 4'hF;
    @(posedge clk);
    @(negedge clk);
    sel[2] = 1'b0;
    @(negedge clk);
    check("w5 mid-wait ready", 32'(rdy[2]), 32'd0);
    rst_n = 1'b0;
    #1;
    check("w5 reset ready", 32'(rdy[2]), 32'd1);
    check("w5 reset error", 32'(errs[2]), 32'd0);
    check("w5 reset rdata", rd[2], 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("w5 held in reset ready", 32'(rdy[2]), 32'd1);
    rst_n = 1'b1;
    access(2, 1'b0, 32'h30, 3'd2, 3'd1, 32'h0, 4'hF, e, r, lows);
    check("w5 post-reset ready_low_cycles", 32'(lows), 32'd5);
    check("w5 post-reset word unchanged", r, 32'h600DCAFE);
    access(0, 1'b0, 32'h10, 3'd2, 3'd1, 32'h0, 4'hF, e, r, lows);
    check("w0 memory survives reset", r, 32'hDEADBEAA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
